// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, stall, flush and forwarding control for a 5-stage pipeline.
// Define FORWARDING_EN to enable EX/MEM and MEM/WB bypass; otherwise any EX/MEM RAW stalls.
module pipeline_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_src1,
    input  logic [4:0] id_src2,
    input  logic [4:0] id_dest,
    input  logic       id_uses_src2,
    input  logic       id_writes_dest,
    input  logic       id_is_load,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_if,
    output logic       flush_id,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] state
);
    typedef enum logic [1:0] {RUN = 2'b00, LDSTALL = 2'b01, FLUSH = 2'b10, MEMWAIT = 2'b11} state_t;
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       writes;
        logic       is_load;
    } slot_t;
    state_t     r_state;
    slot_t      r_ex, r_mem, r_wb;
    logic [4:0] r_ex_src1, r_ex_src2;
    logic       r_ex_uses2;
    logic       w_br, w_ldu, w_id_hit_ex;
    logic       w_unused;
    function automatic logic hit(input slot_t s, input logic [4:0] r);
        return s.valid && s.writes && s.dest != 5'd0 && s.dest == r;
    endfunction
    assign w_id_hit_ex = id_valid && (hit(r_ex, id_src1) || (id_uses_src2 && hit(r_ex, id_src2)));
    assign w_br = ex_branch_taken && r_ex.valid;
`ifdef FORWARDING_EN
    // Loads cannot bypass from EX/MEM, so they are excluded from the nearer source.
    function automatic logic [1:0] sel(input slot_t m, input slot_t w, input logic [4:0] r);
        return (hit(m, r) && !m.is_load) ? 2'b01 : hit(w, r) ? 2'b10 : 2'b00;
    endfunction
    assign w_ldu = w_id_hit_ex && r_ex.is_load;
    assign fwd_a = (rst || !r_ex.valid) ? 2'b00 : sel(r_mem, r_wb, r_ex_src1);
    assign fwd_b = (rst || !r_ex.valid || !r_ex_uses2) ? 2'b00 : sel(r_mem, r_wb, r_ex_src2);
    assign w_unused = r_wb.is_load;
`else
    // Register file writes before reads, so only EX and MEM writers can stall.
    logic w_id_hit_mem;
    assign w_id_hit_mem = id_valid && (hit(r_mem, id_src1) || (id_uses_src2 && hit(r_mem, id_src2)));
    assign w_ldu = w_id_hit_ex || w_id_hit_mem;
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    assign w_unused = ^{r_ex.is_load, r_mem.is_load, r_wb, r_ex_src1, r_ex_src2, r_ex_uses2};
`endif
    assign stall_if = !rst && (mem_busy || (!w_br && w_ldu));
    assign stall_id = stall_if;
    assign flush_if = !rst && !mem_busy && w_br;
    assign flush_id = flush_if;
    assign state = r_state;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_ex_src1  <= '0;
            r_ex_src2  <= '0;
            r_ex_uses2 <= 1'b0;
        end else if (mem_busy) begin
            r_state <= MEMWAIT;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_br || w_ldu) begin
                r_ex.valid <= 1'b0;
                r_state    <= w_br ? FLUSH : LDSTALL;
            end else begin
                r_ex       <= '{id_valid, id_dest, id_writes_dest, id_is_load};
                r_ex_src1  <= id_src1;
                r_ex_src2  <= id_src2;
                r_ex_uses2 <= id_uses_src2;
                r_state    <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed checks of pipeline_ctrl against a slot-list model.
module tb_pipeline_ctrl;
    typedef struct packed {
        logic       v;
        logic [4:0] s1, s2, d;
        logic       u2, w, ld;
    } ins_t;
    localparam ins_t NOP = '0;
    logic clk = 1'b0, rst = 1'b1;
    logic id_valid = 1'b0, id_uses_src2 = 1'b0, id_writes_dest = 1'b0, id_is_load = 1'b0;
    logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic ex_branch_taken = 1'b0, mem_busy = 1'b0;
    logic stall_if, stall_id, flush_if, flush_id;
    logic [1:0] fwd_a, fwd_b, state;
    logic [9:0] obs_vec, exp_vec;
    int checks = 0, failures = 0;
    ins_t m_ex = '0, m_mem = '0, m_wb = '0;
    logic [1:0] m_state = 2'd0;
    assign obs_vec = {stall_if, stall_id, flush_if, flush_id, fwd_a, fwd_b, state};
    always #5 clk = ~clk;
    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_dest(id_dest), .id_uses_src2(id_uses_src2), .id_writes_dest(id_writes_dest),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .flush_if(flush_if), .flush_id(flush_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state)
    );
    function automatic ins_t mk(input int s1, s2, d, input bit u2, w, ld);
        ins_t i;
        i.v = 1'b1; i.s1 = 5'(s1); i.s2 = 5'(s2); i.d = 5'(d); i.u2 = u2; i.w = w; i.ld = ld;
        return i;
    endfunction
    function automatic bit writes_reg(input ins_t e, input logic [4:0] r);
        return r != 0 && e.v && e.w && e.d == r;
    endfunction
    function automatic bit reads_from(input ins_t producer, input ins_t i);
        return i.v && (writes_reg(producer, i.s1) || (i.u2 && writes_reg(producer, i.s2)));
    endfunction
    function automatic logic [1:0] src_of(input logic [4:0] r, input bit en);
        if (!en || !m_ex.v) return 2'd0;
`ifdef FORWARDING_EN
        if (writes_reg(m_mem, r) && !m_mem.ld) return 2'd1;
        if (writes_reg(m_wb, r)) return 2'd2;
`endif
        return 2'd0;
    endfunction
    // Applies one cycle of stimulus, records the expected outputs, then advances the model.
    task automatic drive(input ins_t i, input bit br, input bit busy, input bit r);
        bit brt, ldu, st, fl;
        @(negedge clk);
        id_valid = i.v; id_src1 = i.s1; id_src2 = i.s2; id_dest = i.d;
        id_uses_src2 = i.u2; id_writes_dest = i.w; id_is_load = i.ld;
        ex_branch_taken = br; mem_busy = busy; rst = r;
        #1;
        brt = br && m_ex.v;
`ifdef FORWARDING_EN
        ldu = reads_from(m_ex, i) && m_ex.ld;
`else
        ldu = reads_from(m_ex, i) || reads_from(m_mem, i);
`endif
        st = !r && (busy || (!brt && ldu));
        fl = !r && !busy && brt;
        exp_vec = {st, st, fl, fl, r ? 2'd0 : src_of(m_ex.s1, 1'b1), r ? 2'd0 : src_of(m_ex.s2, m_ex.u2), m_state};
        if (r) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_state = 2'd0;
        end else if (busy) begin
            m_state = 2'd3;
        end else begin
            m_wb = m_mem;
            m_mem = m_ex;
            if (brt || ldu) begin
                m_ex.v = 1'b0;
                m_state = brt ? 2'd2 : 2'd1;
            end else begin
                m_ex = i;
                m_state = 2'd0;
            end
        end
    endtask
    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            drive(mk($urandom % 4, $urandom % 4, 2, 1, 1, 1), 1, 1, 1);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset cyc%0d obs=%b exp=%b", n, obs_vec, exp_vec); end
        end
        checks++;
        if (obs_vec !== 10'd0) begin failures++; $display("FAIL reset_zero obs=%b exp=%b", obs_vec, 10'd0); end
    endtask
    task automatic run_prog(input string name, input ins_t prog[$], output int stalls);
        stalls = 0;
        foreach (prog[k]) for (int n = 0; n < 8; n++) begin
            drive(prog[k], 0, 0, 0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL %s ins%0d obs=%b exp=%b", name, k, obs_vec, exp_vec); end
            if (!exp_vec[9]) break;
            stalls++;
        end
    endtask
    task automatic test_forwarding();
        int stalls;
        drive(NOP, 0, 0, 1);
        run_prog("fwd_adjacent", '{mk(5, 6, 2, 1, 1, 0), mk(2, 9, 7, 0, 1, 0), NOP, NOP, NOP}, stalls);
`ifdef FORWARDING_EN
        checks++; if (stalls !== 0) begin failures++; $display("FAIL fwd_adjacent_stalls obs=%0d exp=0", stalls); end
`else
        checks++; if (stalls !== 2) begin failures++; $display("FAIL fwd_adjacent_stalls obs=%0d exp=2", stalls); end
`endif
        run_prog("fwd_gap", '{mk(5, 6, 2, 1, 1, 0), mk(8, 0, 4, 0, 1, 0), mk(2, 9, 7, 0, 1, 0), NOP, NOP, NOP}, stalls);
`ifdef FORWARDING_EN
        checks++; if (stalls !== 0) begin failures++; $display("FAIL fwd_gap_stalls obs=%0d exp=0", stalls); end
`else
        checks++; if (stalls !== 1) begin failures++; $display("FAIL fwd_gap_stalls obs=%0d exp=1", stalls); end
`endif
        run_prog("fwd_r0", '{mk(1, 1, 0, 1, 1, 1), mk(0, 0, 5, 1, 1, 0), NOP, NOP}, stalls);
        checks++; if (stalls !== 0) begin failures++; $display("FAIL r0_stalls obs=%0d exp=0", stalls); end
    endtask
    task automatic test_load_use();
        int stalls;
        drive(NOP, 0, 0, 1);
        run_prog("load_use", '{mk(1, 0, 3, 0, 1, 1), mk(0, 3, 6, 1, 1, 0), NOP, NOP, NOP}, stalls);
`ifdef FORWARDING_EN
        checks++; if (stalls !== 1) begin failures++; $display("FAIL load_use_stalls obs=%0d exp=1", stalls); end
`else
        checks++; if (stalls !== 2) begin failures++; $display("FAIL load_use_stalls obs=%0d exp=2", stalls); end
`endif
    endtask
    task automatic test_branch();
        drive(NOP, 0, 0, 1);
        drive(mk(1, 2, 4, 1, 1, 0), 0, 0, 0);
        drive(mk(4, 0, 5, 0, 1, 0), 1, 0, 0);
        checks++; if (obs_vec !== exp_vec) begin failures++; $display("FAIL branch_take obs=%b exp=%b", obs_vec, exp_vec); end
        checks++; if (flush_if !== 1'b1) begin failures++; $display("FAIL branch_flush obs=%b exp=1", flush_if); end
        drive(mk(4, 0, 5, 0, 1, 0), 1, 0, 0);
        checks++; if (obs_vec !== exp_vec) begin failures++; $display("FAIL branch_after obs=%b exp=%b", obs_vec, exp_vec); end
        checks++; if ({flush_id, state} !== 3'b010) begin failures++; $display("FAIL branch_state obs=%b exp=010", {flush_id, state}); end
        drive(mk(1, 2, 3, 1, 1, 0), 1, 1, 0);
        checks++; if (obs_vec !== exp_vec) begin failures++; $display("FAIL branch_busy obs=%b exp=%b", obs_vec, exp_vec); end
    endtask
    task automatic test_memwait();
        int stalls = 0;
        ins_t use3 = mk(3, 0, 6, 0, 1, 0);
        drive(NOP, 0, 0, 1);
        drive(mk(1, 0, 3, 0, 1, 1), 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            drive(use3, 0, 1, 0);
            checks++; if (obs_vec !== exp_vec) begin failures++; $display("FAIL memwait cyc%0d obs=%b exp=%b", n, obs_vec, exp_vec); end
            stalls += int'(stall_if);
        end
        checks++; if ({stalls, state} !== {32'd3, 2'd3}) begin failures++; $display("FAIL memwait_held stalls=%0d state=%0d exp 3/3", stalls, state); end
        drive(use3, 0, 0, 0);
        checks++; if ({stall_if, state} !== 3'b111) begin failures++; $display("FAIL memwait_release obs=%b exp=111", {stall_if, state}); end
        drive(use3, 0, 0, 0);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL memwait_ldstall obs=%0d exp=1", state); end
        for (int n = 0; n < 3; n++) begin
            drive(use3, 0, 0, 0);
            checks++; if (obs_vec !== exp_vec) begin failures++; $display("FAIL memwait_tail cyc%0d obs=%b exp=%b", n, obs_vec, exp_vec); end
        end
    endtask
    task automatic test_random();
        ins_t i;
        drive(NOP, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            i = mk($urandom % 4, $urandom % 4, $urandom % 4, 1'($urandom), 1'($urandom), 1'($urandom));
            i.v = ($urandom % 4) != 0;
            drive(i, ($urandom % 5) == 0, ($urandom % 6) == 0, ($urandom % 50) == 0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL random cyc%0d obs=%b exp=%b", n, obs_vec, exp_vec); end
        end
    endtask
    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_memwait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
